// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and memory buses of the data-memory arbiter
//   slave  : arbiter view (requests/memory read data in; grants, read data and memory controls out)
//   master : requester + memory view (mirror of slave)
//   r0_* port 0 (CPU data), r1_* port 1 (loader/debug), m_* single-port memory side
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          r0_req, r0_we, r0_gnt, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_we;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output m_addr, m_wdata, m_we,
        input  m_rdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  m_addr, m_wdata, m_we,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter for a single-port data memory with bounded owner tenure
//   clk    : rising-edge clock
//   clr    : asynchronous active-high reset
//   io_bus : dmem_arbiter_if.slave (port 0/1 request buses, memory addr/wdata/we out, rdata in)
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input logic         clk,
    input logic         clr,
    dmem_arbiter_if.slave io_bus
);
    localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} st_t;

    st_t           r_st, w_st_nx, w_yst;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_last, w_xreq, w_yreq, w_gnt0, w_gnt1;
    logic          r_rv0, r_rv1;
    logic [DW-1:0] r_rd0, r_rd1;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    assign w_gnt0  = (r_st == OWN0) && io_bus.r0_req;
    assign w_gnt1  = (r_st == OWN1) && io_bus.r1_req;
    assign w_addr  = w_gnt0 ? io_bus.r0_addr : w_gnt1 ? io_bus.r1_addr : '0;
    assign w_wdata = w_gnt0 ? io_bus.r0_wdata : w_gnt1 ? io_bus.r1_wdata : '0;

    assign io_bus.r0_gnt    = w_gnt0;
    assign io_bus.r1_gnt    = w_gnt1;
    assign io_bus.m_addr    = w_addr;
    assign io_bus.m_wdata   = w_wdata;
    assign io_bus.m_we      = (w_gnt0 && io_bus.r0_we) || (w_gnt1 && io_bus.r1_we);
    assign io_bus.r0_rvalid = r_rv0;
    assign io_bus.r1_rvalid = r_rv1;
    assign io_bus.r0_rdata  = r_rd0;
    assign io_bus.r1_rdata  = r_rd1;

    // Owner X hands over to Y when Y waits and X is done or has used its tenure;
    // the tenure counter saturates so a waiting Y is served after at most MAX_HOLD transfers.
    always_comb begin
        w_st_nx  = r_st;
        w_cnt_nx = '0;
        w_xreq   = (r_st == OWN1) ? io_bus.r1_req : io_bus.r0_req;
        w_yreq   = (r_st == OWN1) ? io_bus.r0_req : io_bus.r1_req;
        w_yst    = (r_st == OWN1) ? OWN0 : OWN1;
        if (r_st == IDLE)
            w_st_nx = (io_bus.r0_req && io_bus.r1_req) ? (r_last ? OWN0 : OWN1) :
                      io_bus.r0_req ? OWN0 : io_bus.r1_req ? OWN1 : IDLE;
        else if (w_yreq && (!w_xreq || r_cnt == CMAX))
            w_st_nx = w_yst;
        else if (!w_xreq)
            w_st_nx = IDLE;
        else
            w_cnt_nx = (r_cnt == CMAX) ? r_cnt : r_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_st   <= IDLE;
            r_cnt  <= '0;
            r_last <= 1'b1;
        end else begin
            r_st  <= w_st_nx;
            r_cnt <= w_cnt_nx;
            if (w_st_nx != IDLE) r_last <= (w_st_nx == OWN1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rv0 <= 1'b0;
            r_rv1 <= 1'b0;
            r_rd0 <= '0;
            r_rd1 <= '0;
        end else begin
            r_rv0 <= w_gnt0 && !io_bus.r0_we;
            r_rv1 <= w_gnt1 && !io_bus.r1_we;
            if (w_gnt0 && !io_bus.r0_we) r_rd0 <= io_bus.m_rdata;
            if (w_gnt1 && !io_bus.r1_we) r_rd1 <= io_bus.m_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a tenure/round-robin reference model
module tb_dmem_arbiter;
    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] mem [0:63];
    logic [31:0] sh  [0:63];
    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    logic        rq [2];
    logic        w  [2];
    logic [31:0] a  [2];
    logic [31:0] d  [2];

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
    dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(MH)) dut (.clk(clk), .clr(clr), .io_bus(bus.slave));

    always #5 clk = ~clk;

    assign bus.m_rdata = mem[bus.m_addr[7:2]];
    always @(posedge clk) if (bus.m_we) mem[bus.m_addr[7:2]] = bus.m_wdata;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int p, input logic r, input logic we, input logic [31:0] ad, input logic [31:0] wd);
        if (p == 0) begin
            bus.r0_req = r; bus.r0_we = we; bus.r0_addr = ad; bus.r0_wdata = wd;
        end else begin
            bus.r1_req = r; bus.r1_we = we; bus.r1_addr = ad; bus.r1_wdata = wd;
        end
    endtask

    task automatic do_reset;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        tot_cnt++; if ({bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.m_we} !== 5'b0) $display("FAIL rst_flags got %b exp 00000", {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.m_we}); else pass_cnt++;
        tot_cnt++; if ({bus.r0_rdata, bus.r1_rdata} !== 64'h0) $display("FAIL rst_rdata got %h exp 0", {bus.r0_rdata, bus.r1_rdata}); else pass_cnt++;
        tot_cnt++; if (bus.m_addr !== 32'h0) $display("FAIL rst_maddr got %h exp 0", bus.m_addr); else pass_cnt++;
        tick();
        drv(1, 1, 0, 32'h8, 0);
        tick();
        @(negedge clk);
        tot_cnt++; if (bus.r1_gnt !== 1'b1) $display("FAIL rst_own1_gnt got %b exp 1", bus.r1_gnt); else pass_cnt++;
        tick();
        tot_cnt++; if ({bus.r1_rvalid, bus.r1_rdata} !== {1'b1, sh[2]}) $display("FAIL rst_own1_rd got %h exp %h", {bus.r1_rvalid, bus.r1_rdata}, {1'b1, sh[2]}); else pass_cnt++;
        clr = 1'b1;
        #1;
        tot_cnt++; if ({bus.r1_gnt, bus.m_we, bus.r1_rvalid} !== 3'b0) $display("FAIL rst_mid_flags got %b exp 000", {bus.r1_gnt, bus.m_we, bus.r1_rvalid}); else pass_cnt++;
        tot_cnt++; if (bus.r1_rdata !== 32'h0) $display("FAIL rst_mid_rdata got %h exp 0", bus.r1_rdata); else pass_cnt++;
        drv(0, 1, 0, 32'h0, 0);
        clr = 1'b0;
        tick();
        @(negedge clk);
        tot_cnt++; if ({bus.r0_gnt, bus.r1_gnt} !== 2'b10) $display("FAIL rst_first_contend got %b exp 10", {bus.r0_gnt, bus.r1_gnt}); else pass_cnt++;
    endtask

    task automatic test_write_read;
        do_reset();
        drv(0, 1, 1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        tot_cnt++; if (bus.r0_gnt !== 1'b0) $display("FAIL wr_c0_gnt got %b exp 0", bus.r0_gnt); else pass_cnt++;
        tick();
        @(negedge clk);
        tot_cnt++; if ({bus.r0_gnt, bus.m_we, bus.m_addr, bus.m_wdata} !== {2'b11, 32'h10, 32'hDEADBEEF}) $display("FAIL wr_c1 got %h exp %h", {bus.r0_gnt, bus.m_we, bus.m_addr, bus.m_wdata}, {2'b11, 32'h10, 32'hDEADBEEF}); else pass_cnt++;
        tick();
        sh[4] = 32'hDEADBEEF;
        drv(0, 1, 0, 32'h10, 0);
        @(negedge clk);
        tot_cnt++; if ({bus.r0_gnt, bus.m_we} !== 2'b10) $display("FAIL rd_gnt got %b exp 10", {bus.r0_gnt, bus.m_we}); else pass_cnt++;
        tick();
        drv(0, 0, 0, 0, 0);
        drv(1, 1, 0, 32'h10, 0);
        tot_cnt++; if ({bus.r0_rvalid, bus.r0_rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL rd0_data got %h exp %h", {bus.r0_rvalid, bus.r0_rdata}, {1'b1, 32'hDEADBEEF}); else pass_cnt++;
        tick();
        @(negedge clk);
        tot_cnt++; if ({bus.r1_gnt, bus.r0_rvalid, bus.r0_rdata} !== {2'b10, 32'hDEADBEEF}) $display("FAIL rd0_hold got %h exp %h", {bus.r1_gnt, bus.r0_rvalid, bus.r0_rdata}, {2'b10, 32'hDEADBEEF}); else pass_cnt++;
        tick();
        drv(1, 0, 0, 0, 0);
        tot_cnt++; if ({bus.r1_rvalid, bus.r1_rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL rd1_cross got %h exp %h", {bus.r1_rvalid, bus.r1_rdata}, {1'b1, 32'hDEADBEEF}); else pass_cnt++;
    endtask

    task automatic test_priority;
        logic [1:0] e [5] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        do_reset();
        drv(0, 1, 0, 32'h0, 0);
        drv(1, 1, 0, 32'h4, 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) drv(0, 0, 0, 0, 0);
            @(negedge clk);
            tot_cnt++; if ({bus.r0_gnt, bus.r1_gnt} !== e[k]) $display("FAIL prio c%0d got %b exp %b", k, {bus.r0_gnt, bus.r1_gnt}, e[k]); else pass_cnt++;
            tick();
        end
        drv(1, 0, 0, 0, 0);
    endtask

    task automatic test_round_robin;
        logic e0;
        logic [1:0] pe = 2'b00;
        do_reset();
        drv(0, 1, 0, 32'h20, 0);
        drv(1, 1, 0, 32'h24, 0);
        tick();
        for (int k = 0; k < 24; k++) begin
            e0 = ((k / MH) % 2) == 0;
            @(negedge clk);
            tot_cnt++; if ({bus.r0_gnt, bus.r1_gnt} !== {e0, !e0}) $display("FAIL rr_gnt k=%0d got %b exp %b", k, {bus.r0_gnt, bus.r1_gnt}, {e0, !e0}); else pass_cnt++;
            tot_cnt++; if ({bus.r0_rvalid, bus.r1_rvalid} !== pe) $display("FAIL rr_rvalid k=%0d got %b exp %b", k, {bus.r0_rvalid, bus.r1_rvalid}, pe); else pass_cnt++;
            pe = {e0, !e0};
            tick();
        end
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        do_reset();
        drv(1, 1, 0, 32'h0, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tot_cnt++; if ({bus.r1_gnt, bus.m_addr} !== {1'b1, 32'(i * 4)}) $display("FAIL b2b_gnt i=%0d got %h exp %h", i, {bus.r1_gnt, bus.m_addr}, {1'b1, 32'(i * 4)}); else pass_cnt++;
            if (i > 0) begin
                tot_cnt++; if ({bus.r1_rvalid, bus.r1_rdata} !== {1'b1, sh[i-1]}) $display("FAIL b2b_data i=%0d got %h exp %h", i, {bus.r1_rvalid, bus.r1_rdata}, {1'b1, sh[i-1]}); else pass_cnt++;
            end
            tick();
            drv(1, i < 7, 0, 32'((i + 1) * 4), 0);
        end
        @(negedge clk);
        tot_cnt++; if ({bus.r1_rvalid, bus.r1_rdata} !== {1'b1, sh[7]}) $display("FAIL b2b_last got %h exp %h", {bus.r1_rvalid, bus.r1_rdata}, {1'b1, sh[7]}); else pass_cnt++;
    endtask

    task automatic test_withdraw;
        do_reset();
        drv(0, 1, 1, 32'h40, 32'h12345678);
        @(negedge clk);
        tot_cnt++; if (bus.r0_gnt !== 1'b0) $display("FAIL wd_c0 got %b exp 0", bus.r0_gnt); else pass_cnt++;
        tick();
        drv(0, 0, 0, 0, 0);
        @(negedge clk);
        tot_cnt++; if ({bus.r0_gnt, bus.m_we} !== 2'b00) $display("FAIL wd_c1 got %b exp 00", {bus.r0_gnt, bus.m_we}); else pass_cnt++;
        tick();
        drv(0, 1, 0, 32'h0, 0);
        drv(1, 1, 0, 32'h4, 0);
        @(negedge clk);
        tot_cnt++; if ({bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.m_we} !== 4'b0) $display("FAIL wd_idle got %b exp 0000", {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.m_we}); else pass_cnt++;
        tot_cnt++; if (mem[16] !== sh[16]) $display("FAIL wd_mem got %h exp %h", mem[16], sh[16]); else pass_cnt++;
        tick();
        @(negedge clk);
        tot_cnt++; if ({bus.r0_gnt, bus.r1_gnt} !== 2'b01) $display("FAIL wd_next_rr got %b exp 01", {bus.r0_gnt, bus.r1_gnt}); else pass_cnt++;
        tick();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
    endtask

    task automatic test_random;
        int          own = -1;
        int          ten = 0;
        int          last = 1;
        logic        eg  [2];
        logic        erv [2];
        logic        gp  [2];
        logic [31:0] erd [2];
        do_reset();
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; gp[p] = 0; erv[p] = 0; erd[p] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || gp[p]) begin
                    rq[p] = $urandom_range(0, 3) != 0;
                    w[p]  = $urandom_range(0, 1) == 1;
                    a[p]  = 32'($urandom_range(0, 63)) << 2;
                    d[p]  = $urandom;
                end else if ($urandom_range(0, 9) == 0) rq[p] = 0;
                drv(p, rq[p], w[p], a[p], d[p]);
                eg[p] = (own == p) && rq[p];
            end
            @(negedge clk);
            tot_cnt++; if ({bus.r0_gnt, bus.r1_gnt} !== {eg[0], eg[1]}) $display("FAIL rnd_gnt c=%0d got %b exp %b", c, {bus.r0_gnt, bus.r1_gnt}, {eg[0], eg[1]}); else pass_cnt++;
            tot_cnt++; if (bus.m_we !== ((eg[0] && w[0]) || (eg[1] && w[1]))) $display("FAIL rnd_we c=%0d got %b exp %b", c, bus.m_we, (eg[0] && w[0]) || (eg[1] && w[1])); else pass_cnt++;
            tot_cnt++; if ({bus.m_addr, bus.m_wdata} !== (eg[0] ? {a[0], d[0]} : eg[1] ? {a[1], d[1]} : 64'h0)) $display("FAIL rnd_mux c=%0d got %h", c, {bus.m_addr, bus.m_wdata}); else pass_cnt++;
            tot_cnt++; if ({bus.r0_rvalid, bus.r1_rvalid} !== {erv[0], erv[1]}) $display("FAIL rnd_rvalid c=%0d got %b exp %b", c, {bus.r0_rvalid, bus.r1_rvalid}, {erv[0], erv[1]}); else pass_cnt++;
            tot_cnt++; if ({bus.r0_rdata, bus.r1_rdata} !== {erd[0], erd[1]}) $display("FAIL rnd_rdata c=%0d got %h exp %h", c, {bus.r0_rdata, bus.r1_rdata}, {erd[0], erd[1]}); else pass_cnt++;
            for (int p = 0; p < 2; p++) begin
                erv[p] = eg[p] && !w[p];
                if (erv[p]) erd[p] = sh[a[p][7:2]];
                if (eg[p] && w[p]) sh[a[p][7:2]] = d[p];
                gp[p] = eg[p];
            end
            if (own < 0) begin
                if (rq[0] && rq[1]) own = (last == 1) ? 0 : 1;
                else if (rq[0]) own = 0;
                else if (rq[1]) own = 1;
                if (own >= 0) begin ten = 1; last = own; end
            end else if (rq[1-own] && (!rq[own] || ten >= MH)) begin
                own = 1 - own; ten = 1; last = own;
            end else if (!rq[own]) own = -1;
            else ten++;
            tick();
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            mem[i] = v;
            sh[i]  = v;
        end
        test_reset();
        test_write_read();
        test_priority();
        test_round_robin();
        test_back_to_back();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
